// File: rtl/keyenc_pkg.sv
// Shared definitions for the keypad encoder: FSM state encoding, key count
// and BCD code width.
package keyenc_pkg;

  localparam int KEY_N  = 10;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    EMIT = 2'd2,
    HELD = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_encode_10to4_if.sv
// Key/code bus of the keypad encoder.
// Handshake: the encoder raises vld with a stable y; y and vld hold until the
// rising clock edge where vld && rdy are both high, which completes the
// transfer. vld never depends combinationally on rdy.
// err is a one-cycle pulse reporting a rejected multi-key press (0 unless the
// encoder is built with KEYENC_MULTI_ERR_EN).
interface keypad_encode_10to4_if;
  import keyenc_pkg::*;

  logic [KEY_N-1:0]  I;
  logic              rdy;
  logic [CODE_W-1:0] y;
  logic              vld;
  logic              err;

  // Encoder side: consumes raw keys and rdy, produces the code.
  modport master (input I, input rdy, output y, output vld, output err);
  // Consumer / keypad side.
  modport slave (output I, output rdy, input y, input vld, input err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, one independent chain per bit.
// Synchronous active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Shift the asynchronous input through two capture stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encode_10to4.sv
// Registered 10-line to 4-bit BCD key encoder with synchroniser, press and
// release debounce and a valid/ready output. One code per press.
// Optional build macro: KEYENC_MULTI_ERR_EN -- reject multi-key presses with
// a one-cycle err pulse instead of encoding the highest pressed key.
module keypad_encode_10to4
  import keyenc_pkg::*;
#(
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  keypad_encode_10to4_if.master        bus,
  output state_t                       dbg_state
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [KEY_N-1:0]  w_s;
  state_t            r_state, w_state_nx;
  logic [KEY_N-1:0]  r_snap, w_snap_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [CODE_W-1:0] r_y, w_y_nx;
  logic              r_vld, w_vld_nx;
  logic              w_s_zero;
  logic              w_cnt_done;

  // Highest set index wins; key 9 has top priority.
  function automatic logic [CODE_W-1:0] encode(input logic [KEY_N-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (v[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

`ifdef KEYENC_MULTI_ERR_EN
  logic r_err, w_err_nx;
  logic w_multi;
  // More than one key in the accepted snapshot.
  assign w_multi = (r_snap & (r_snap - KEY_N'(1))) != '0;
`endif

  sync_2ff #(.WIDTH(KEY_N)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.I),
    .o_q (w_s)
  );

  assign w_s_zero   = (w_s == '0);
  assign w_cnt_done = (r_cnt == LP_CNT_MAX);

  // Next-state and next-register values; everything holds unless a state
  // rule updates it.
  always_comb begin
    w_state_nx = r_state;
    w_snap_nx  = r_snap;
    w_cnt_nx   = r_cnt;
    w_y_nx     = r_y;
    w_vld_nx   = r_vld;
`ifdef KEYENC_MULTI_ERR_EN
    w_err_nx   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_s_zero) begin
          w_snap_nx  = w_s;
          w_cnt_nx   = '0;
          w_state_nx = DEB;
        end
      end
      DEB: begin
        if (w_s_zero) begin
          w_state_nx = IDLE;
        end else if (w_s != r_snap) begin
          w_snap_nx = w_s;
          w_cnt_nx  = '0;
        end else if (w_cnt_done) begin
`ifdef KEYENC_MULTI_ERR_EN
          if (w_multi) begin
            w_err_nx   = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = HELD;
          end else begin
            w_y_nx     = encode(r_snap);
            w_vld_nx   = 1'b1;
            w_state_nx = EMIT;
          end
`else
          w_y_nx     = encode(r_snap);
          w_vld_nx   = 1'b1;
          w_state_nx = EMIT;
`endif
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      EMIT: begin
        // Key activity is ignored here; only the handshake moves on.
        if (r_vld && bus.rdy) begin
          w_vld_nx   = 1'b0;
          w_cnt_nx   = '0;
          w_state_nx = HELD;
        end
      end
      HELD: begin
        if (!w_s_zero) begin
          w_cnt_nx = '0;
        end else if (w_cnt_done) begin
          w_cnt_nx   = '0;
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_snap  <= w_snap_nx;
      r_cnt   <= w_cnt_nx;
      r_y     <= w_y_nx;
      r_vld   <= w_vld_nx;
    end
  end

`ifdef KEYENC_MULTI_ERR_EN
  // Registered one-cycle reject pulse.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_nx;
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.y     = r_y;
  assign bus.vld   = r_vld;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_encode_10to4.sv
// Self-checking bench for keypad_encode_10to4 (DEBOUNCE=4): directed test
// plan steps followed by random key/rdy traffic, every cycle compared against
// a run-length reference model.
module tb_keypad_encode_10to4;
  import keyenc_pkg::*;

  localparam int DEB_N = 4;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  keypad_encode_10to4_if kbus ();

  keypad_encode_10to4 #(.DEBOUNCE(DEB_N), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (kbus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_xfer = 0;
  int n_err  = 0;
  logic [3:0] last_y = '0;

  // Reference model: a key is accepted after DEB_N+1 consecutive edges of the
  // same non-zero synchronised value; after a transfer (or reject) it waits for
  // DEB_N consecutive edges of all-zero before looking for a new press.
  int         m_mode;    // 0 = looking for press, 1 = presenting code, 2 = waiting release
  int         m_run;
  int         m_zero;
  logic [9:0] m_run_val;
  logic [9:0] m_s1, m_s2;
  logic       m_vld, m_err;
  logic [3:0] m_y;

  function automatic logic [3:0] top_key(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_run = 0; m_zero = 0; m_run_val = '0;
      m_s1 = '0; m_s2 = '0; m_vld = 1'b0; m_err = 1'b0; m_y = '0;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        0: begin
          if (m_s2 == '0) m_run = 0;
          else if (m_run > 0 && m_s2 == m_run_val) m_run++;
          else begin m_run_val = m_s2; m_run = 1; end
          if (m_run == DEB_N + 1) begin
`ifdef KEYENC_MULTI_ERR_EN
            if ($countones(m_run_val) > 1) begin
              m_err = 1'b1; m_mode = 2; m_zero = 0;
            end else begin
              m_y = top_key(m_run_val); m_vld = 1'b1; m_mode = 1;
            end
`else
            m_y = top_key(m_run_val); m_vld = 1'b1; m_mode = 1;
`endif
          end
        end
        1: if (kbus.rdy) begin m_vld = 1'b0; m_mode = 2; m_zero = 0; end
        default: begin
          if (m_s2 == '0) begin
            m_zero++;
            if (m_zero == DEB_N) begin m_mode = 0; m_run = 0; end
          end else m_zero = 0;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = kbus.I;
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance model at the edge, sample DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("vld", 32'(kbus.vld), 32'(m_vld));
    chk("y",   32'(kbus.y),   32'(m_y));
    chk("err", 32'(kbus.err), 32'(m_err));
    if (kbus.vld) last_y = kbus.y;
    if (kbus.vld && kbus.rdy) n_xfer++;
    if (kbus.err) n_err++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (!kbus.vld && lat < 40) begin step(); lat++; end
  endtask

  task automatic release_keys();
    kbus.I = '0;
    steps(DEB_N + 6);
  endtask

  int         lat;
  int         x0, e0;
  logic [9:0] pat;
  int         hold;

  initial begin
    rst = 1'b1; kbus.I = 10'h3FF; kbus.rdy = 1'b1;
    // 1. Reset with all keys pressed, then key 9 after release of rst.
    steps(3);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    #1 rst = 1'b0;
    wait_vld(lat);
    chk("lat_reset", lat, 32'(3 + DEB_N));
    chk("y_reset", 32'(kbus.y), 32'd9);
    step();
    release_keys();

    // 2. Single key 3 with rdy high: one pulse, none while held.
    x0 = n_xfer;
    kbus.I = 10'b0000001000;
    wait_vld(lat);
    chk("lat_single", lat, 32'(3 + DEB_N));
    chk("y_single", 32'(kbus.y), 32'd3);
    steps(20);
    chk("single_count", n_xfer - x0, 1);
    release_keys();

    // 3. Backpressure: key 7 held in EMIT, input change ignored.
    kbus.rdy = 1'b0;
    kbus.I = 10'b0010000000;
    wait_vld(lat);
    steps(5);
    kbus.I = 10'b0000000100;
    steps(15);
    chk("bp_vld", 32'(kbus.vld), 32'd1);
    chk("bp_y", 32'(kbus.y), 32'd7);
    kbus.rdy = 1'b1;
    step();
    chk("bp_drop", 32'(kbus.vld), 32'd0);
    release_keys();

    // 4. Press bounce and release glitches: one code with y=5.
    x0 = n_xfer;
    kbus.I = 10'b0000100000; steps(2);
    kbus.I = '0;             steps(1);
    kbus.I = 10'b0000100000; steps(15);
    chk("bounce_y", 32'(last_y), 32'd5);
    kbus.I = '0;             steps(2);
    kbus.I = 10'b0000100000; steps(1);
    kbus.I = '0;             steps(2);
    kbus.I = 10'b0000100000; steps(1);
    release_keys();
    chk("bounce_count", n_xfer - x0, 1);

    // 5. Multi-key press 9+1.
    x0 = n_xfer; e0 = n_err;
    kbus.I = 10'b1000000010;
    steps(15);
`ifdef KEYENC_MULTI_ERR_EN
    chk("multi_err", n_err - e0, 1);
    chk("multi_xfer", n_xfer - x0, 0);
`else
    chk("multi_xfer", n_xfer - x0, 1);
    chk("multi_y", 32'(last_y), 32'd9);
`endif
    release_keys();

    // 6. Reset during EMIT, key still held afterwards.
    kbus.rdy = 1'b0;
    kbus.I = 10'b0000010000;
    wait_vld(lat);
    chk("pre_rst_vld", 32'(kbus.vld), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_emit_vld", 32'(kbus.vld), 32'd0);
    rst = 1'b0;
    wait_vld(lat);
    chk("lat_after_rst", lat, 32'(3 + DEB_N));
    chk("y_after_rst", 32'(kbus.y), 32'd4);
    kbus.rdy = 1'b1;
    step();
    release_keys();

    // Random traffic: idle, single keys and occasional multi-key presses.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0:       pat = '0;
        1:       pat = 10'($urandom_range(1, 1023));
        default: pat = 10'(1) << $urandom_range(0, 9);
      endcase
      kbus.I = pat;
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        kbus.rdy = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_encode_10to4.md
# keypad_encode_10to4

Registered 10-line to 4-bit BCD key encoder: the return path for the team's 4-to-10 one-hot decoder. It takes ten raw, asynchronous, active-high decimal key lines, synchronises and debounces them, and encodes the stable pressed key to a 4-bit BCD code (0–9). Each code is presented once per press on a valid/ready handshake. It sits between a front-panel or keypad and the control logic that consumes digits.

## Interface
Parameters:
- DEBOUNCE, default 16: consecutive stable synchronised cycles required to accept a press or a release. Legal range is 1–65535.
- CNT_W, default 16: width of the debounce counter. It must satisfy 2^CNT_W > DEBOUNCE.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: the only clock. All state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- I, input, 10: raw key lines, asynchronous to clk. Bit n set means decimal key n is pressed.
- rdy, input, 1: consumer is ready to take the code.
- y, output, 4: BCD code of the accepted key. Registered; stable while vld is high.
- vld, output, 1: code valid. Held until vld && rdy.
- err, output, 1: one-cycle pulse when a multi-key press is rejected. Exists only when KEYENC_MULTI_ERR_EN is defined (see Configuration); otherwise it is tied to 0.

## Operation
- Synchroniser: I passes through a 2-flop synchroniser per bit. The synchronised value is s[9:0]. All decisions use s only.
- FSM states are IDLE, DEB, EMIT and HELD. Reset state is IDLE.
- IDLE:
  - If s != 0: snap <= s, cnt <= 0, go to DEB.
  - Otherwise stay in IDLE.
- DEB:
  - If s == 0: go to IDLE (bounce).
  - Else if s != snap: snap <= s, cnt <= 0 (restart).
  - Else if cnt == DEBOUNCE-1: accept.
  - Else: cnt <= cnt+1.
- Accept:
  - y <= encode(snap), vld <= 1, go to EMIT.
  - encode() returns the highest set bit index (priority encoder, 9 has top priority).
- EMIT:
  - vld and y hold while rdy is low.
  - On vld && rdy: vld <= 0, cnt <= 0, go to HELD.
  - Input changes during EMIT are ignored.
- HELD:
  - Waits for release. If s == 0, cnt increments; if s != 0, cnt <= 0.
  - When s == 0 with cnt == DEBOUNCE-1: go to IDLE.
  - No new code is issued until the release is debounced. This gives exactly one code per press.
- Arithmetic:
  - cnt never wraps, because it is cleared on every state entry and capped at DEBOUNCE-1.
  - y is always in the range 0–9. Codes 10–15 are never produced.
- Reset mid-operation: rst in any state forces IDLE, vld=0, y=0, err=0, cnt=0, snap=0 and clears the synchroniser flops. A press in progress is discarded. A key still held after reset is treated as a new press.

## Timing
- Reset values: y=4'b0000, vld=0, err=0.
- Latency: if I is stable and non-zero from clock edge k, vld rises after edge k+3+DEBOUNCE.
  - 2 cycles for the synchroniser.
  - 1 cycle for the IDLE capture.
  - DEBOUNCE cycles in DEB.
- Handshake:
  - vld does not depend combinationally on rdy.
  - Transfer completes on the edge where vld && rdy are both high. vld is low on the next cycle.
  - If rdy is high before vld rises, the transfer completes at the first vld cycle, so vld is a 1-cycle pulse.
- Release: HELD to IDLE takes DEBOUNCE cycles of s == 0 after the edge that completes the transfer.
- Throughput: at most one code per press/release pair.

## Configuration
- Macro KEYENC_MULTI_ERR_EN.
- When defined:
  - At accept, if snap has more than one bit set, no code is emitted: vld stays 0 and y is unchanged.
  - err pulses high for exactly 1 cycle, then the FSM goes to HELD, which waits for full release.
- When undefined:
  - err is tied to 0.
  - A multi-hot snap encodes to its highest set index.

## Structure
- Shared package keyenc_pkg holds:
  - the state encodings (IDLE=2'd0, DEB=2'd1, EMIT=2'd2, HELD=2'd3);
  - the key count constant (10);
  - the code width constant (4).
- Sub-module sync_2ff is parameterised by width and instantiated at 10 bits. The sub-module is natural and reusable.
- Encode and the FSM live in keypad_encode_10to4.

## Test plan
All scenarios use DEBOUNCE=4 unless stated.
1. Reset: hold rst for 3 cycles with I=10'h3FF. Required: y=0, vld=0, err=0 throughout reset. After release, a key 9 press is emitted 7 cycles later.
2. Single key with rdy=1: I=10'b0000001000 held from edge k. Required: vld=1 and y=3 for exactly one cycle after edge k+7. No second vld while the key is held.
3. Backpressure: key 7 pressed with rdy=0. Required: vld=1 and y=7 held for 20 cycles. The cycle after rdy is raised, vld=0. Changing I to key 2 during EMIT has no effect.
4. Bounce: key 5 toggles on for 2 cycles, off for 1, then held steady. Required: only one vld with y=5. Release glitches shorter than 4 cycles do not allow a second code.
5. Multi-key: I=10'b1000000010.
   - With KEYENC_MULTI_ERR_EN: one err pulse, no vld.
   - Without it: vld with y=9.
6. Reset mid-EMIT: assert rst while vld=1. Required: vld=0 on the next cycle. After rst drops with the key still held, that key is re-emitted after 7 cycles.
